single_port_async_read_sram: RTL and testbench



---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_mem_array.sv | 44 ++++
 rtl/single_port_async_read_sram.sv | 73 +++++++
 tb/tb_single_port_async_read_sram.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_pkg                                                      |
// | Purpose  : Shared defaults and the address-width helper for the          |
// |            single-port asynchronous-read SRAM.                           |
// | Contents : SRAM_W_DEF  - default word width (8)                          |
// |            SRAM_D_DEF  - default depth in words (16)                     |
// |            sram_aw(d)  - address width for d words, never below 1        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package sram_pkg;

  localparam int SRAM_W_DEF = 8;
  localparam int SRAM_D_DEF = 16;

  // $clog2(1) would be 0, which would make a zero-width address bus.
  function automatic int sram_aw(input int d);
    int aw;
    aw = $clog2(d);
    return (aw < 1) ? 1 : aw;
  endfunction

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_mem_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_mem_array                                                |
// | Purpose  : Storage array with synchronous reset-clear and one            |
// |            synchronous write port. The whole array is exposed so the     |
// |            parent can build a combinational read mux.                    |
// | Ports    : clk        in  1      rising-edge clock                       |
// |            rst        in  1      synchronous active-high clear           |
// |            i_wr_en    in  1      write strobe (already range-qualified)  |
// |            i_wr_addr  in  AW     write address                           |
// |            i_wr_data  in  W      write data                              |
// |            o_mem      out D x W  current array contents                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sram_mem_array
  import sram_pkg::*;
#(
  parameter int W  = SRAM_W_DEF,
  parameter int D  = SRAM_D_DEF,
  parameter int AW = sram_aw(D)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [W-1:0]          i_wr_data,
  output logic [D-1:0][W-1:0]   o_mem
);

  logic [D-1:0][W-1:0] r_mem;

  // Reset has priority: a write presented on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_mem = r_mem;

endmodule : sram_mem_array
`default_nettype wire

// File: rtl/single_port_async_read_sram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : single_port_async_read_sram                                   |
// | Purpose  : Single-port SRAM, synchronous write, combinational read on a  |
// |            shared address bus. Out-of-range addresses read 0 and never   |
// |            write.                                                        |
// | Ports    : clk       in  1   rising-edge clock                           |
// |            rst       in  1   synchronous active-high clear of all words  |
// |            ad        in  AW  shared read/write address                   |
// |            data_in   in  W   write data                                  |
// |            w_en      in  1   write enable                                |
// |            data_out  out W   mem[ad], combinational                      |
// | Config   : SRAM_WR_BYPASS_EN - when defined, an in-range write forwards  |
// |            data_in to data_out before the edge (write-first). Undefined: |
// |            data_out always shows the stored word (read-old-data).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module single_port_async_read_sram
  import sram_pkg::*;
#(
  parameter  int W  = SRAM_W_DEF,
  parameter  int D  = SRAM_D_DEF,
  localparam int AW = sram_aw(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ad,
  input  logic [W-1:0]  data_in,
  input  logic          w_en,
  output logic [W-1:0]  data_out
);

  // One extra bit so the depth itself is representable for the compare.
  localparam logic [AW:0] c_DEPTH = (AW+1)'(D);

  logic                w_in_range;
  logic                w_wr_en;
  logic [D-1:0][W-1:0] w_mem;
  logic [W-1:0]        w_rd_data;

  assign w_in_range = ({1'b0, ad} < c_DEPTH);
  assign w_wr_en    = w_en & w_in_range;

  sram_mem_array #(
    .W  (W),
    .D  (D),
    .AW (AW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (ad),
    .i_wr_data (data_in),
    .o_mem     (w_mem)
  );

  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      w_rd_data = w_mem[ad];
    end
  end

`ifdef SRAM_WR_BYPASS_EN
  // Forwarding ignores rst on purpose: the forwarded word is shown but a
  // simultaneous reset still prevents it from being stored.
  assign data_out = w_wr_en ? data_in : w_rd_data;
`else
  assign data_out = w_rd_data;
`endif

endmodule : single_port_async_read_sram
`default_nettype wire

// File: tb/tb_single_port_async_read_sram.sv
`default_nettype none
`timescale 1ns/10ps
// +--------------------------------------------------------------------------+
// | Module   : tb_single_port_async_read_sram                                |
// | Purpose  : Self-checking bench for the 16 x 8 single-port async-read     |
// |            SRAM: directed scenarios plus randomized traffic checked      |
// |            against an array reference model. Honors SRAM_WR_BYPASS_EN.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_single_port_async_read_sram;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ad = '0;
  logic [7:0] data_in = '0;
  logic       w_en = 1'b0;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [16];

  single_port_async_read_sram #(
    .W (8),
    .D (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ad       (ad),
    .data_in  (data_in),
    .w_en     (w_en),
    .data_out (data_out)
  );

  always #0.5 clk = ~clk;

  // Expected combinational output for the current inputs and model state.
  function automatic logic [7:0] mexp();
`ifdef SRAM_WR_BYPASS_EN
    if (w_en) return data_in;
`endif
    return model[ad];
  endfunction

  // Advance one rising edge, apply the storage rules to the model, then
  // move 0.1 ns past the edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
    end else if (w_en) begin
      model[ad] = data_in;
    end
    #0.1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (data_out === exp)
    else begin
      errors++;
      $error("FAIL %s ad=%0d observed=%h expected=%h", tag, ad, data_out, exp);
    end
  endtask

  initial begin
    #5000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'hxx;

    // 1. reset then sweep all addresses
    #0.2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      ad = 4'(a);
      #0.05;
      chk("reset_sweep", 8'h00);
    end

    // 2. single write then read back
    tick();
    ad = 4'd3; data_in = 8'hA5; w_en = 1'b1;
    tick();
    w_en = 1'b0; ad = 4'd3;
    chk("write_readback", 8'hA5);

    // 3. fill 0..9, read all
    for (int a = 0; a < 10; a++) begin
      ad = 4'(a); data_in = 8'h10 + 8'(a); w_en = 1'b1;
      tick();
    end
    w_en = 1'b0;
    for (int a = 0; a < 16; a++) begin
      ad = 4'(a);
      #0.05;
      chk("fill_read", (a < 10) ? (8'h10 + 8'(a)) : 8'h00);
    end

    // 4. overwrite same word, neighbours untouched
    tick();
    ad = 4'd5; data_in = 8'h12; w_en = 1'b1;
    tick();
    data_in = 8'h34;
    tick();
    w_en = 1'b0;
    ad = 4'd4; #0.05; chk("overwrite_n4", 8'h14);
    ad = 4'd5; #0.05; chk("overwrite_5", 8'h34);
    ad = 4'd6; #0.05; chk("overwrite_n6", 8'h16);

    // 5. address toggles propagate without a clock edge
    tick();
    ad = 4'd3; #0.05; chk("toggle_3", 8'h13);
    ad = 4'd5; #0.05; chk("toggle_5", 8'h34);
    ad = 4'd3; #0.05; chk("toggle_3b", 8'h13);

    // read-during-write to the same address
    tick();
    ad = 4'd3; data_in = 8'h77; w_en = 1'b1;
    #0.1;
`ifdef SRAM_WR_BYPASS_EN
    chk("rdw_before_edge", 8'h77);
`else
    chk("rdw_before_edge", 8'h13);
`endif
    tick();
    w_en = 1'b0;
    chk("rdw_after_edge", 8'h77);

    // 6. reset beats a simultaneous write
    ad = 4'd2; data_in = 8'hFF; w_en = 1'b1; rst = 1'b1;
    #0.1;
`ifdef SRAM_WR_BYPASS_EN
    chk("rst_wr_before", 8'hFF);
`else
    chk("rst_wr_before", 8'h12);
`endif
    tick();
    rst = 1'b0; w_en = 1'b0;
    chk("rst_wins_2", 8'h00);
    ad = 4'd5; #0.05; chk("rst_clears_5", 8'h00);

`ifdef SRAM_WR_BYPASS_EN
    ad = 4'd7; data_in = 8'h5A; w_en = 1'b1;
    #0.1;
    chk("bypass_fwd", 8'h5A);
    tick();
    w_en = 1'b0;
    chk("bypass_stored", 8'h5A);
`endif

    // randomized traffic against the array model
    tick();
    for (int n = 0; n < 300; n++) begin
      ad      = 4'($urandom_range(0, 15));
      w_en    = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      rst     = ($urandom_range(0, 39) == 0);
      #0.1;
      chk("rand_pre", mexp());
      tick();
      chk("rand_post", mexp());
      rst  = 1'b0;
      w_en = 1'b0;
      ad   = 4'($urandom_range(0, 15));
      #0.05;
      chk("rand_read", model[ad]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_single_port_async_read_sram
`default_nettype wire
